// File: rtl/axi_gmem_responder.sv
// rtl/axi_gmem_responder.sv - AXI4 slave word-addressed RAM model for the kernel gmem port
//
// Ports:
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   s_axi_AW* / s_axi_W*    write address and write data channels (INCR, full width)
//   s_axi_B*                write response channel (BRESP 2'b10 on range or WLAST error)
//   s_axi_AR* / s_axi_R*    read address and read data channels (RRESP 2'b10 out of range)
// Read and write sides are independent FSMs, each with one transaction in flight.

module axi_gmem_responder #(
    parameter int C_ID_WIDTH   = 1,
    parameter int C_DATA_WIDTH = 64,
    parameter int C_ADDR_WIDTH = 64,
    parameter int C_MEM_WORDS  = 1024,
    parameter     C_INIT_FILE  = ""
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      s_axi_AWVALID,
    output logic                      s_axi_AWREADY,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_AWADDR,
    input  logic [C_ID_WIDTH-1:0]     s_axi_AWID,
    input  logic [7:0]                s_axi_AWLEN,
    input  logic                      s_axi_WVALID,
    output logic                      s_axi_WREADY,
    input  logic [C_DATA_WIDTH-1:0]   s_axi_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] s_axi_WSTRB,
    input  logic                      s_axi_WLAST,
    output logic                      s_axi_BVALID,
    input  logic                      s_axi_BREADY,
    output logic [C_ID_WIDTH-1:0]     s_axi_BID,
    output logic [1:0]                s_axi_BRESP,
    input  logic                      s_axi_ARVALID,
    output logic                      s_axi_ARREADY,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_ARADDR,
    input  logic [C_ID_WIDTH-1:0]     s_axi_ARID,
    input  logic [7:0]                s_axi_ARLEN,
    output logic                      s_axi_RVALID,
    input  logic                      s_axi_RREADY,
    output logic [C_DATA_WIDTH-1:0]   s_axi_RDATA,
    output logic [C_ID_WIDTH-1:0]     s_axi_RID,
    output logic [1:0]                s_axi_RRESP,
    output logic                      s_axi_RLAST
);
    localparam int STRB_W = C_DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(C_MEM_WORDS);
    localparam int HI     = LSB + IDX_W;

    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2;

    logic [C_DATA_WIDTH-1:0] mem_q [C_MEM_WORDS];

    // Any address bit above the word-index field marks the access out of range.
    logic aw_oor, ar_oor;
    assign aw_oor = |(s_axi_AWADDR >> HI);
    assign ar_oor = |(s_axi_ARADDR >> HI);

    // ---------------- write side ----------------
    logic [1:0]            w_state_q, w_state_d;
    logic [IDX_W-1:0]      w_idx_q, w_idx_d;
    logic [7:0]            w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic                  w_oor_q, w_oor_d, w_err_q, w_err_d;
    logic [C_ID_WIDTH-1:0] bid_q, bid_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  mem_we;

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_oor_d   = w_oor_q;
        w_err_d   = w_err_q;
        bid_d     = bid_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (awready_q && s_axi_AWVALID) begin
                w_state_d = W_DATA;
                w_idx_d   = s_axi_AWADDR[LSB +: IDX_W];
                w_len_d   = s_axi_AWLEN;
                w_beat_d  = 8'd0;
                w_oor_d   = aw_oor;
                w_err_d   = aw_oor;
                bid_d     = s_axi_AWID;
            end
            W_DATA: if (wready_q && s_axi_WVALID) begin
                mem_we   = !w_oor_q;
                // Burst length is owned by AWLEN; a misplaced WLAST only flags the response.
                if (s_axi_WLAST != (w_beat_q == w_len_q)) w_err_d = 1'b1;
                w_idx_d  = w_idx_q + 1'b1;
                w_beat_d = w_beat_q + 8'd1;
                if (w_beat_q == w_len_q) w_state_d = W_RESP;
            end
            W_RESP: if (bvalid_q && s_axi_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        // Handshake outputs are registered copies of the next state, so they read 0 in reset.
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = (bvalid_d && w_err_d) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge ap_clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_WSTRB[b]) mem_q[w_idx_q][b*8 +: 8] <= s_axi_WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read side ----------------
    logic [1:0]              r_state_q, r_state_d;
    logic [IDX_W-1:0]        r_idx_q, r_idx_d;
    logic [7:0]              r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic                    r_oor_q, r_oor_d;
    logic [C_ID_WIDTH-1:0]   rid_q, rid_d;
    logic                    arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_oor_d   = r_oor_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: if (arready_q && s_axi_ARVALID) begin
                r_state_d = R_FETCH;
                r_idx_d   = s_axi_ARADDR[LSB +: IDX_W];
                r_len_d   = s_axi_ARLEN;
                r_beat_d  = 8'd0;
                r_oor_d   = ar_oor;
                rid_d     = s_axi_ARID;
            end
            // Registering the array read here gives read-first behaviour against a same-edge write.
            R_FETCH: begin
                r_state_d = R_DATA;
                rdata_d   = r_oor_q ? '0 : mem_q[r_idx_q];
                rresp_d   = r_oor_q ? 2'b10 : 2'b00;
                rlast_d   = (r_beat_q == r_len_q);
            end
            R_DATA: if (rvalid_q && s_axi_RREADY) begin
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                    rlast_d   = 1'b0;
                end else begin
                    r_state_d = R_FETCH;
                    r_idx_d   = r_idx_q + 1'b1;
                    r_beat_d  = r_beat_q + 8'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_oor_q   <= 1'b0;
            w_err_q   <= 1'b0;
            bid_q     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_oor_q   <= 1'b0;
            rid_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_oor_q   <= w_oor_d;
            w_err_q   <= w_err_d;
            bid_q     <= bid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_oor_q   <= r_oor_d;
            rid_q     <= rid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi_AWREADY = awready_q;
    assign s_axi_WREADY  = wready_q;
    assign s_axi_BVALID  = bvalid_q;
    assign s_axi_BID     = bid_q;
    assign s_axi_BRESP   = bresp_q;
    assign s_axi_ARREADY = arready_q;
    assign s_axi_RVALID  = rvalid_q;
    assign s_axi_RDATA   = rdata_q;
    assign s_axi_RID     = rid_q;
    assign s_axi_RRESP   = rresp_q;
    assign s_axi_RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_gmem_responder.sv
// tb/tb_axi_gmem_responder.sv - self-checking bench for axi_gmem_responder

module tb_axi_gmem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [63:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [0:0]  AWID, BID, ARID, RID;
    logic [7:0]  AWLEN, ARLEN, WSTRB;
    logic [1:0]  BRESP, RRESP;

    always #5 clk = ~clk;

    axi_gmem_responder #(.C_ID_WIDTH(1), .C_DATA_WIDTH(64), .C_ADDR_WIDTH(64), .C_MEM_WORDS(1024), .C_INIT_FILE("")) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axi_AWVALID(AWVALID), .s_axi_AWREADY(AWREADY), .s_axi_AWADDR(AWADDR), .s_axi_AWID(AWID), .s_axi_AWLEN(AWLEN),
        .s_axi_WVALID(WVALID), .s_axi_WREADY(WREADY), .s_axi_WDATA(WDATA), .s_axi_WSTRB(WSTRB), .s_axi_WLAST(WLAST),
        .s_axi_BVALID(BVALID), .s_axi_BREADY(BREADY), .s_axi_BID(BID), .s_axi_BRESP(BRESP),
        .s_axi_ARVALID(ARVALID), .s_axi_ARREADY(ARREADY), .s_axi_ARADDR(ARADDR), .s_axi_ARID(ARID), .s_axi_ARLEN(ARLEN),
        .s_axi_RVALID(RVALID), .s_axi_RREADY(RREADY), .s_axi_RDATA(RDATA), .s_axi_RID(RID), .s_axi_RRESP(RRESP), .s_axi_RLAST(RLAST)
    );

    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic id; } rbeat_t;
    typedef struct { logic [1:0] resp; logic id; } bresp_t;

    logic [63:0] mdl [1024];
    rbeat_t      exp_r[$];
    bresp_t      exp_b[$];
    int          checks = 0;
    int          errors = 0;
    int          r_hs = 0;
    logic [63:0] last_rdata;
    logic [1:0]  last_rresp, last_bresp;
    logic        last_rlast, last_bid;
    logic        bp = 1'b0;
    logic [63:0] wd [16];
    logic [7:0]  ws [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", nm);
    endtask

    // Ready backpressure: random when bp is set, otherwise always ready.
    initial begin
        RREADY = 1'b1;
        BREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            RREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            BREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: every R/B handshake against the model queues, plus stall stability.
    initial begin
        logic pv_rv, pv_rr, pv_rl, pv_bv, pv_br;
        logic [63:0] pv_rd;
        rbeat_t e;
        bresp_t eb;
        pv_rv = 1'b0; pv_rr = 1'b0; pv_rl = 1'b0; pv_bv = 1'b0; pv_br = 1'b0; pv_rd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv_rv = 1'b0;
                pv_bv = 1'b0;
            end else begin
                if (pv_rv && !pv_rr) begin
                    chk("r_stall_valid", RVALID, 1);
                    chk("r_stall_data", RDATA, pv_rd);
                    chk("r_stall_last", RLAST, pv_rl);
                end
                if (pv_bv && !pv_br) chk("b_stall_valid", BVALID, 1);
                if (RVALID && RREADY) begin
                    r_hs++;
                    last_rdata = RDATA; last_rresp = RRESP; last_rlast = RLAST;
                    if (exp_r.size() == 0) timeout("r_unexpected_beat");
                    else begin
                        e = exp_r.pop_front();
                        chk("r_data", RDATA, e.data);
                        chk("r_resp", RRESP, e.resp);
                        chk("r_last", RLAST, e.last);
                        chk("r_id", RID, e.id);
                    end
                end
                if (BVALID && BREADY) begin
                    last_bresp = BRESP; last_bid = BID;
                    if (exp_b.size() == 0) timeout("b_unexpected");
                    else begin
                        eb = exp_b.pop_front();
                        chk("b_resp", BRESP, eb.resp);
                        chk("b_id", BID, eb.id);
                    end
                end
                pv_rv = RVALID; pv_rr = RREADY; pv_rl = RLAST; pv_rd = RDATA;
                pv_bv = BVALID; pv_br = BREADY;
            end
        end
    end

    // Write burst of len+1 beats from wd/ws; WLAST raised on beat 'early'.
    task automatic do_write(input logic [63:0] addr, input logic id, input int len, input int early);
        int n;
        int idx;
        logic oor, err;
        bresp_t eb;
        oor = (addr >> 13) != 0;
        idx = int'(addr[12:3]);
        err = oor;
        for (int b = 0; b <= len; b++) begin
            if (!oor)
                for (int k = 0; k < 8; k++)
                    if (ws[b][k]) mdl[idx][k*8 +: 8] = wd[b][k*8 +: 8];
            if ((b == early) != (b == len)) err = 1'b1;
            idx = (idx + 1) % 1024;
        end
        eb.resp = err ? 2'b10 : 2'b00;
        eb.id = id;
        exp_b.push_back(eb);

        @(posedge clk); #1;
        AWVALID = 1'b1; AWADDR = addr; AWID = id; AWLEN = 8'(len);
        n = 0;
        do begin @(negedge clk); n++; end while (!AWREADY && n < 50);
        if (!AWREADY) timeout("aw_wait");
        @(posedge clk); #1;
        AWVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            WVALID = 1'b1; WDATA = wd[b]; WSTRB = ws[b]; WLAST = (b == early);
            n = 0;
            do begin @(negedge clk); n++; end while (!WREADY && n < 50);
            if (!WREADY) timeout("w_wait");
            @(posedge clk); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        n = 0;
        while (exp_b.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (exp_b.size() != 0) begin timeout("b_wait"); exp_b.delete(); end
    endtask

    task automatic start_read(input logic [63:0] addr, input logic id, input int len, input bit meas);
        int n;
        int idx;
        logic oor;
        rbeat_t e;
        oor = (addr >> 13) != 0;
        idx = int'(addr[12:3]);
        for (int b = 0; b <= len; b++) begin
            e.data = oor ? 64'd0 : mdl[idx];
            e.resp = oor ? 2'b10 : 2'b00;
            e.last = (b == len);
            e.id = id;
            exp_r.push_back(e);
            idx = (idx + 1) % 1024;
        end
        @(posedge clk); #1;
        ARVALID = 1'b1; ARADDR = addr; ARID = id; ARLEN = 8'(len);
        n = 0;
        do begin @(negedge clk); n++; end while (!ARREADY && n < 50);
        if (!ARREADY) timeout("ar_wait");
        @(posedge clk); #1;
        ARVALID = 1'b0;
        if (meas) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!RVALID && n < 10);
            chk("ar_to_rvalid_cycles", 64'(n), 64'd2);
        end
    endtask

    task automatic wait_read();
        int n;
        n = 0;
        while (exp_r.size() != 0 && n < 600) begin @(negedge clk); n++; end
        if (exp_r.size() != 0) begin timeout("r_wait"); exp_r.delete(); end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int h0;
        rst_n = 1'b0;
        AWVALID = 0; AWADDR = 0; AWID = 0; AWLEN = 0;
        WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0;
        ARVALID = 0; ARADDR = 0; ARID = 0; ARLEN = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", AWREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_resp", {BRESP, RRESP}, 0);
        chk("rst_ids", {BID, RID}, 0);
        #1 rst_n = 1'b1;
        #1 chk("release_arready_pre_edge", ARREADY, 0);
        @(negedge clk);
        chk("release_awready", AWREADY, 1);
        chk("release_arready", ARREADY, 1);

        // single beat write/read at 0x40
        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        do_write(64'h40, 1'b1, 0, 0);
        chk("t1_bresp", last_bresp, 0);
        chk("t1_bid", last_bid, 1);
        start_read(64'h40, 1'b0, 0, 1'b1);
        wait_read();
        chk("t1_rdata", last_rdata, 64'h1122334455667788);
        chk("t1_rlast", last_rlast, 1);

        // strobe merge over an all-ones prefill
        for (int i = 0; i < 4; i++) begin wd[i] = '1; ws[i] = 8'hFF; end
        do_write(64'h100, 1'b0, 3, 3);
        for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
        ws[2] = 8'h0F;
        do_write(64'h100, 1'b1, 3, 3);
        chk("t2_model_word34", mdl[34], 64'hFFFFFFFF00000003);
        start_read(64'h100, 1'b1, 3, 1'b0);
        wait_read();
        chk("t2_last_rdata", last_rdata, 64'd4);

        // 16-beat burst under random backpressure
        bp = 1'b1;
        for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(64'h400, 1'b0, 15, 15);
        h0 = r_hs;
        start_read(64'h400, 1'b0, 15, 1'b0);
        wait_read();
        chk("t3_beat_count", 64'(r_hs - h0), 64'd16);
        bp = 1'b0;

        // index wrap from word 1022
        for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0 + 64'(i); ws[i] = 8'hFF; end
        do_write(64'h1FF0, 1'b1, 3, 3);
        start_read(64'h1FF0, 1'b1, 3, 1'b0);
        wait_read();
        chk("t4_model_word0", mdl[0], 64'hA2);
        start_read(64'h0, 1'b0, 1, 1'b0);
        wait_read();
        chk("t4_word1", last_rdata, 64'hA3);

        // out-of-range and WLAST errors
        start_read(64'h2000, 1'b1, 1, 1'b0);
        wait_read();
        chk("t5_oor_rresp", last_rresp, 2'b10);
        chk("t5_oor_rdata", last_rdata, 0);
        wd[0] = 64'hDEAD_BEEF; ws[0] = 8'hFF;
        do_write(64'h2000, 1'b0, 0, 0);
        chk("t5_oor_bresp", last_bresp, 2'b10);
        start_read(64'h0, 1'b0, 0, 1'b0);
        wait_read();
        chk("t5_word0_kept", last_rdata, 64'hA2);
        wd[0] = 64'h55; wd[1] = 64'h66; ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(64'h200, 1'b1, 1, 0);
        chk("t5_early_wlast_bresp", last_bresp, 2'b10);
        do_write(64'h200, 1'b0, 0, 0);
        chk("t5_err_cleared_bresp", last_bresp, 2'b00);

        // reset in the middle of a read burst
        start_read(64'h400, 1'b0, 15, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!RVALID && n < 10);
        if (!RVALID) timeout("t6_rvalid_wait");
        #1 rst_n = 1'b0;
        #1 chk("t6_rvalid_in_reset", RVALID, 0);
        exp_r.delete();
        @(negedge clk);
        chk("t6_arready_in_reset", ARREADY, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_arready_after", ARREADY, 1);
        start_read(64'h40, 1'b1, 0, 1'b0);
        wait_read();
        chk("t6_data_survives", last_rdata, 64'h1122334455667788);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
